// File: rtl/mem_slave.sv
// 256 x 16 bus slave: zero-fill sweep after reset, writes, and reads with READ_LAT-cycle latency.
// Optional MEM_SLAVE_STATUS_EN maps a saturating write counter at address 8'hFF.
module mem_slave #(
    parameter int unsigned READ_LAT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        write_i,
    input  logic [15:0] data_in_i,
    input  logic [7:0]  address_i,
    output logic [15:0] data_out_o,
    output logic        init_done_o
);

    typedef enum logic {StInit, StReady} state_e;

    state_e              state_q;
    logic [7:0]          ptr_q;
    logic [15:0]         mem_q [256];
    logic [READ_LAT-1:0] vld_q;
    logic [15:0]         dat_q [READ_LAT];
    logic [15:0]         rd_data;
    logic [15:0]         stage0_d;
    logic                wr_accept;

`ifdef MEM_SLAVE_STATUS_EN
    logic [15:0] wr_count_q;

    always_comb begin
        wr_accept = (state_q == StReady) && write_i && (address_i != 8'hFF);
        rd_data   = (address_i == 8'hFF) ? wr_count_q : mem_q[address_i];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_count_q <= 16'h0000;
        end else if (wr_accept && (wr_count_q != 16'hFFFF)) begin
            wr_count_q <= wr_count_q + 16'd1;
        end
    end
`else
    always_comb begin
        wr_accept = (state_q == StReady) && write_i;
        rd_data   = mem_q[address_i];
    end
`endif

    // Reads sampled during the sweep still complete, but always with zero data.
    always_comb begin
        stage0_d = (state_q == StInit) ? 16'h0000 : rd_data;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state_q == StInit) begin
                mem_q[ptr_q] <= 16'h0000;
            end else if (wr_accept) begin
                mem_q[address_i] <= data_in_i;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StInit;
            ptr_q       <= 8'h00;
            init_done_o <= 1'b0;
        end else if (state_q == StInit) begin
            ptr_q <= ptr_q + 8'd1;
            if (ptr_q == 8'hFF) begin
                state_q     <= StReady;
                init_done_o <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q      <= '0;
            data_out_o <= 16'h0000;
            for (int i = 0; i < int'(READ_LAT); i++) begin
                dat_q[i] <= 16'h0000;
            end
        end else begin
            vld_q[0] <= !write_i;
            dat_q[0] <= stage0_d;
            for (int i = 1; i < int'(READ_LAT); i++) begin
                vld_q[i] <= vld_q[i-1];
                dat_q[i] <= dat_q[i-1];
            end
            if (vld_q[READ_LAT-1]) begin
                data_out_o <= dat_q[READ_LAT-1];
            end
        end
    end

endmodule

// File: tb/tb_mem_slave.sv
// Randomized bench for mem_slave (READ_LAT = 3) against a transaction-level model.
module tb_mem_slave;

    localparam int Lat = 3;
`ifdef MEM_SLAVE_STATUS_EN
    localparam bit StatusEn = 1'b1;
`else
    localparam bit StatusEn = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        write_i;
    logic [15:0] data_in_i;
    logic [7:0]  address_i;
    logic [15:0] data_out_o;
    logic        init_done_o;

    mem_slave #(
        .READ_LAT(Lat)
    ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .write_i    (write_i),
        .data_in_i  (data_in_i),
        .address_i  (address_i),
        .data_out_o (data_out_o),
        .init_done_o(init_done_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          due;
        logic [15:0] d;
    } pend_t;

    logic [15:0] ref_mem [256];
    logic [15:0] ref_cnt;
    logic [15:0] exp_out;
    int          sweep;
    int          cyc_n;
    pend_t       pend_q [$];
    int          n_cmp;
    int          n_err;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", tag, cyc_n, got, exp);
        end
    endtask

    // Model: after a reset the array is all zeros by the time it is usable, so clear it at once.
    task automatic model_edge(input logic r, input logic w, input logic [7:0] a,
                              input logic [15:0] d);
        bit          in_init;
        logic [15:0] val;
        cyc_n++;
        if (r) begin
            pend_q.delete();
            exp_out = 16'h0000;
            sweep   = 0;
            ref_cnt = 16'h0000;
            for (int i = 0; i < 256; i++) ref_mem[i] = 16'h0000;
            return;
        end
        in_init = (sweep < 256);
        while (pend_q.size() > 0 && pend_q[0].due == cyc_n) begin
            exp_out = pend_q[0].d;
            void'(pend_q.pop_front());
        end
        if (!w) begin
            if (in_init) val = 16'h0000;
            else if (StatusEn && a == 8'hFF) val = ref_cnt;
            else val = ref_mem[a];
            pend_q.push_back('{due: cyc_n + Lat, d: val});
        end else if (!in_init && !(StatusEn && a == 8'hFF)) begin
            ref_mem[a] = d;
            if (ref_cnt != 16'hFFFF) ref_cnt = ref_cnt + 16'd1;
        end
        if (sweep < 256) sweep++;
    endtask

    task automatic cyc(input logic r, input logic w, input logic [7:0] a, input logic [15:0] d);
        @(negedge clk);
        rst       = r;
        write_i   = w;
        address_i = a;
        data_in_i = d;
        @(posedge clk);
        model_edge(r, w, a, d);
        #1;
        check("data_out", data_out_o, exp_out);
        check("init_done", {15'h0, init_done_o}, {15'h0, sweep >= 256});
    endtask

    task automatic run_sweep();
        for (int i = 0; i < 256 && !init_done_o; i++) begin
            cyc(1'b0, 1'b0, 8'(i), 16'h0000);
        end
        check("sweep_done", {15'h0, init_done_o}, 16'h0001);
    endtask

    initial begin
        logic [7:0]  a;
        logic [15:0] d;
        n_cmp     = 0;
        n_err     = 0;
        cyc_n     = 0;
        sweep     = 0;
        ref_cnt   = 16'h0000;
        exp_out   = 16'h0000;
        rst       = 1'b1;
        write_i   = 1'b0;
        address_i = 8'h00;
        data_in_i = 16'h0000;

        // Reset, then sweep with a write of BEEF to 8'h10 at the 5th edge.
        cyc(1'b1, 1'b0, 8'h00, 16'h0000);
        cyc(1'b1, 1'b0, 8'h00, 16'h0000);
        check("reset_out", data_out_o, 16'h0000);
        for (int i = 1; i <= 255; i++) begin
            if (i == 5) cyc(1'b0, 1'b1, 8'h10, 16'hBEEF);
            else cyc(1'b0, 1'b0, 8'(i), 16'h0000);
        end
        check("init_early", {15'h0, init_done_o}, 16'h0000);
        cyc(1'b0, 1'b0, 8'h10, 16'h0000);
        check("init_256", {15'h0, init_done_o}, 16'h0001);
        cyc(1'b0, 1'b0, 8'h10, 16'h0000);
        for (int i = 0; i < Lat; i++) cyc(1'b0, 1'b0, 8'h10, 16'h0000);
        check("init_write_dropped", data_out_o, 16'h0000);

        // Read-after-write with latency, then hold across writes.
        cyc(1'b0, 1'b1, 8'h22, 16'hA5A5);
        cyc(1'b0, 1'b0, 8'h22, 16'h0000);
        for (int k = 1; k <= 7; k++) begin
            cyc(1'b0, 1'b1, 8'h40, 16'(k));
            if (k >= Lat) check("raw_hold", data_out_o, 16'hA5A5);
        end

        // Streaming reads.
        for (int i = 0; i < 8; i++) cyc(1'b0, 1'b1, 8'(i), 16'h1000 + 16'(i));
        for (int k = 0; k < 11; k++) begin
            cyc(1'b0, 1'b0, (k < 8) ? 8'(k) : 8'h00, 16'h0000);
            if (k >= Lat) check("stream", data_out_o, 16'h1000 + 16'(k - Lat));
        end

        // Reset mid-read: A5A5 must never reach data_out.
        cyc(1'b0, 1'b0, 8'h22, 16'h0000);
        cyc(1'b1, 1'b0, 8'h00, 16'h0000);
        check("midrst_out", data_out_o, 16'h0000);
        cyc(1'b0, 1'b0, 8'h22, 16'h0000);
        cyc(1'b0, 1'b0, 8'h22, 16'h0000);
        check("midrst_out2", data_out_o, 16'h0000);
        run_sweep();
        cyc(1'b0, 1'b0, 8'h22, 16'h0000);
        for (int i = 0; i < Lat; i++) cyc(1'b1 == 1'b0, 1'b1, 8'h41, 16'h0000);
        check("midrst_clear", data_out_o, 16'h0000);

        // Status sequence (counter was cleared by the last reset; only 8'h41 writes so far).
        cyc(1'b1, 1'b0, 8'h00, 16'h0000);
        run_sweep();
        for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, 8'h01, 16'(i));
        cyc(1'b0, 1'b1, 8'hFF, 16'h1234);
        cyc(1'b0, 1'b0, 8'hFF, 16'h0000);
        for (int i = 0; i < Lat; i++) cyc(1'b0, 1'b1, 8'h30, 16'h0000);
        check("status_ff", data_out_o, StatusEn ? 16'h0005 : 16'h1234);

        // Random traffic with occasional resets.
        for (int n = 0; n < 3000; n++) begin
            a = ($urandom_range(0, 3) == 0) ? 8'hF8 + 8'($urandom_range(0, 7))
                                             : 8'($urandom_range(0, 15));
            d = 16'($urandom);
            cyc(($urandom_range(0, 999) == 0) ? 1'b1 : 1'b0, 1'($urandom_range(0, 1)), a, d);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
